// File: rtl/monopix_ro_arbiter.sv
// monopix_ro_arbiter: round-robin readout controller shared by the four MONOPIX flavors.
// Ports: i_clk_bx clock; i_rst_n sync active-low reset; i_en/i_token/i_data_in per-flavor
//        enable, TOKEN and serial OUT pads; o_freeze/o_read one-hot FREEZE/READ pads;
//        o_data_out/o_data_flavor/o_data_valid completed hit word; o_busy FSM not idle.
// Option: define MONOPIX_RO_GRAY_DECODE_EN to emit te/le in binary instead of raw Gray.
module monopix_ro_arbiter #(
  parameter int FREEZE_CYCLES = 3,
  parameter int READ_CYCLES   = 2,
  parameter int DATA_DLY      = 2,
  parameter int WORD_BITS     = 27
) (
  input  logic                 i_clk_bx,
  input  logic                 i_rst_n,
  input  logic [3:0]           i_en,
  input  logic [3:0]           i_token,
  input  logic [3:0]           i_data_in,
  output logic [3:0]           o_freeze,
  output logic [3:0]           o_read,
  output logic [WORD_BITS-1:0] o_data_out,
  output logic [1:0]           o_data_flavor,
  output logic                 o_data_valid,
  output logic                 o_busy
);
  typedef enum logic [2:0] {S_IDLE, S_FREEZE, S_READ, S_WAIT, S_SHIFT, S_ARB} state_t;
  state_t               r_state, w_nxt;
  logic [1:0]           r_sel, w_nxt_sel, r_last, w_win;
  logic [7:0]           r_cnt, w_nxt_cnt;
  logic [3:0]           w_req;
  logic                 w_any, w_strobe;
  logic [WORD_BITS-1:0] r_sr, w_word;
  assign w_req = i_token & i_en;
  assign w_any = |w_req;
  // Scan from the lowest priority (last served) up, so the nearest requester after it wins.
  always_comb begin
    w_win = r_last;
    for (int i = 3; i >= 0; i--)
      if (w_req[r_last + 2'(i + 1)]) w_win = r_last + 2'(i + 1);
  end
  always_comb begin
    w_nxt     = r_state;
    w_nxt_sel = r_sel;
    w_nxt_cnt = r_cnt + 8'd1;
    w_strobe  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_nxt_cnt = 8'd0;
        if (w_any) begin
          w_nxt     = S_FREEZE;
          w_nxt_sel = w_win;
        end
      end
      S_FREEZE:
        if (!i_token[r_sel]) begin
          w_nxt     = S_IDLE;
          w_nxt_cnt = 8'd0;
        end else if (r_cnt == 8'(FREEZE_CYCLES - 1)) begin
          w_nxt     = S_READ;
          w_nxt_cnt = 8'd0;
        end
      S_READ:
        if (r_cnt == 8'(READ_CYCLES - 1)) begin
          w_nxt     = S_WAIT;
          w_nxt_cnt = 8'd0;
        end
      S_WAIT:
        if (r_cnt == 8'(DATA_DLY - 1)) begin
          w_nxt     = S_SHIFT;
          w_nxt_cnt = 8'd0;
        end
      // WORD_BITS sampling cycles, then one cycle that publishes the word.
      S_SHIFT:
        if (r_cnt == 8'(WORD_BITS)) begin
          w_strobe  = 1'b1;
          w_nxt     = S_ARB;
          w_nxt_cnt = 8'd0;
        end
      S_ARB: begin
        w_nxt_cnt = 8'd0;
        w_nxt     = !w_any ? S_IDLE : (w_win == r_sel) ? S_READ : S_FREEZE;
        w_nxt_sel = w_any ? w_win : r_sel;
      end
      default: begin
        w_nxt     = S_IDLE;
        w_nxt_cnt = 8'd0;
      end
    endcase
  end
  always_comb begin
    w_word = r_sr;
`ifdef MONOPIX_RO_GRAY_DECODE_EN
    for (int i = 4; i >= 0; i--) begin
      w_word[15+i] = w_word[16+i] ^ r_sr[15+i];
      w_word[9+i]  = w_word[10+i] ^ r_sr[9+i];
    end
`endif
  end
  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge i_clk_bx) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_sel         <= 2'd0;
      r_cnt         <= 8'd0;
      r_last        <= 2'd3;
      r_sr          <= '0;
      o_freeze      <= 4'd0;
      o_read        <= 4'd0;
      o_data_out    <= '0;
      o_data_flavor <= 2'd0;
      o_data_valid  <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_sel   <= w_nxt_sel;
      r_cnt   <= w_nxt_cnt;
      if (r_state == S_SHIFT && r_cnt < 8'(WORD_BITS)) r_sr <= {r_sr[WORD_BITS-2:0], i_data_in[r_sel]};
      if (w_strobe) begin
        r_last        <= r_sel;
        o_data_out    <= w_word;
        o_data_flavor <= r_sel;
      end
      o_data_valid <= w_strobe;
      o_freeze     <= (w_nxt != S_IDLE) ? 4'd1 << w_nxt_sel : 4'd0;
      o_read       <= (w_nxt == S_READ) ? 4'd1 << w_nxt_sel : 4'd0;
      o_busy       <= w_nxt != S_IDLE;
    end
  end
endmodule
